// File: rtl/fpu_pkg.sv
// fpu_pkg: binary16 format constants and field layout shared by the adder.
package fpu_pkg;
  localparam int EXP_W = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS = 15;
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } hp_t;
endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: leading-zero count of a 15-bit word; an all-zero word reports 15.
module fpu_lzc (
  input  logic [14:0] x,
  output logic [3:0]  n
);
  always_comb begin
    n = 4'd15;
    for (int i = 0; i < 15; i++)
      if (x[i]) n = 4'(14 - i);
  end
endmodule

// File: rtl/fpu.sv
// fpu: registered binary16 adder, round-to-nearest-even, one cycle latency.
module fpu
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Asem,
  input  logic [15:0] Bsem,
  output logic [15:0] Rsem
);
  hp_t a, b, l, s;
  logic a_nan, b_nan, a_inf, b_inf, swap, eff_sub, st, g, r, sb, up, zero;
  logic [4:0] le, se, d, lz, lim, sh;
  logic [10:0] lm, sm, m;
  logic [12:0] sx, al;
  logic [14:0] sum, n;
  logic [3:0] cnt;
  logic [6:0] e;
  logic [16:0] rnd;
  logic [15:0] res;
  assign a = Asem;
  assign b = Bsem;
  assign a_nan = &a.exp && |a.frac;
  assign b_nan = &b.exp && |b.frac;
  assign a_inf = &a.exp && ~|a.frac;
  assign b_inf = &b.exp && ~|b.frac;
  assign swap = Bsem[14:0] > Asem[14:0];
  assign l = swap ? b : a;
  assign s = swap ? a : b;
  assign le = (l.exp == '0) ? 5'd1 : l.exp;
  assign se = (s.exp == '0) ? 5'd1 : s.exp;
  assign lm = {l.exp != '0, l.frac};
  assign sm = {s.exp != '0, s.frac};
  assign d = le - se;
  // Smaller operand carries guard/round in its two low bits; everything shifted past them is sticky.
  assign sx = {sm, 2'b00};
  assign al = sx >> d;
  assign st = |(sx & ~(13'h1fff << d));
  assign eff_sub = l.sign ^ s.sign;
  assign sum = eff_sub ? {1'b0, lm, 3'b000} - {1'b0, al, st} : {1'b0, lm, 3'b000} + {1'b0, al, st};
  fpu_lzc u_lzc (.x(sum), .n(cnt));
  assign lz = {1'b0, cnt} - 5'd1;
  assign lim = le - 5'd1;
  assign sh = (lz < lim) ? lz : lim;
  assign n = sum << sh;
  // A borrowed-in sticky leaves a nonzero remainder below the round bit, so st is re-ORed after shifting.
  assign m = sum[14] ? sum[14:4] : n[13:3];
  assign g = sum[14] ? sum[3] : n[2];
  assign r = sum[14] ? sum[2] : n[1];
  assign sb = (sum[14] ? |sum[1:0] : n[0]) | st;
  assign e = sum[14] ? {2'b00, le} + 7'd1 : {2'b00, le} - {2'b00, sh};
  assign up = g & (r | sb | m[0]);
  // Rounding on the packed {exp,frac} lets a mantissa carry bump the exponent for free.
  assign rnd = {m[10] ? e : 7'd0, m[9:0]} + {16'd0, up};
  assign zero = sum == '0;
  assign res = (a_nan || b_nan || (a_inf && b_inf && eff_sub)) ? QNAN :
               a_inf ? Asem :
               b_inf ? Bsem :
               zero ? {l.sign & s.sign, 15'd0} :
               (rnd[16:10] >= 7'd31) ? (l.sign ? NEG_INF : POS_INF) :
               {l.sign, rnd[14:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) Rsem <= '0;
    else Rsem <= res;
endmodule

// File: tb/tb_fpu.sv
// tb_fpu: scoreboard bench for the binary16 adder against an exact-integer reference.
module tb_fpu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] Asem = '0, Bsem = '0, Rsem;
  typedef struct {
    logic [15:0] a, b, want;
  } item_t;
  item_t q[$];
  item_t it;
  int checks = 0, failures = 0;

  fpu dut (.clk(clk), .rst_n(rst_n), .Asem(Asem), .Bsem(Bsem), .Rsem(Rsem));

  always #5 clk = ~clk;

  // Value of a finite binary16 in units of 2^-24, so every sum is an exact integer.
  function automatic longint val(input logic [15:0] x);
    longint v;
    int ex;
    ex = int'(x[14:10]);
    v = (ex == 0) ? longint'(x[9:0]) : longint'(x[9:0]) + 1024;
    if (ex > 1) v = v << (ex - 1);
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic an, bn, ai, bi, sg;
    longint sm, mg, qv, rem, half;
    int k;
    an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    if (an || bn) return 16'h7E00;
    if (ai && bi && (a[15] != b[15])) return 16'h7E00;
    if (ai) return a;
    if (bi) return b;
    sm = val(a) + val(b);
    if (sm == 0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
    sg = sm < 0;
    mg = sg ? -sm : sm;
    k = 0;
    for (int i = 0; i < 48; i++)
      if ((mg >> i) >= 2048) k = i + 1;
    qv = mg >> k;
    rem = mg - (qv << k);
    if (k > 0) begin
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && qv[0])) qv = qv + 1;
    end
    if (qv == 2048) begin
      qv = 1024;
      k = k + 1;
    end
    if (k == 0 && qv < 1024) return {sg, 5'd0, qv[9:0]};
    if (k + 1 >= 31) return sg ? 16'hFC00 : 16'h7C00;
    return {sg, 5'(k + 1), 10'(qv - 1024)};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] want);
    @(negedge clk);
    Asem = a;
    Bsem = b;
    q.push_back('{a, b, want});
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      it = q.pop_front();
      checks++;
      if (Rsem !== it.want) begin
        failures++;
        $display("FAIL add %h+%h: got %h expected %h", it.a, it.b, Rsem, it.want);
      end
    end
  end

  logic [15:0] dir_a[14] = '{16'h4400, 16'hBA00, 16'h613D, 16'h3C00, 16'h3C01, 16'h3C00, 16'h7BFF,
                             16'h7C00, 16'h7E01, 16'hFC00, 16'h0001, 16'h03FF, 16'h8000, 16'h8000};
  logic [15:0] dir_b[14] = '{16'hC400, 16'h3400, 16'hE129, 16'h1000, 16'h1000, 16'h3C00, 16'h7BFF,
                             16'hFC00, 16'h3C00, 16'h3C00, 16'h0001, 16'h0001, 16'h8000, 16'h0000};
  logic [15:0] dir_r[14] = '{16'h0000, 16'hB800, 16'h4900, 16'h3C00, 16'h3C02, 16'h4000, 16'h7C00,
                             16'h7E00, 16'h7E00, 16'hFC00, 16'h0002, 16'h0400, 16'h8000, 16'h0000};

  initial begin
    logic [15:0] ra, rb;
    Asem = 16'h3C00;
    Bsem = 16'h4000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Rsem !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hold: got %h expected 0000", Rsem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    Asem = 16'hCA60;
    Bsem = 16'hC460;
    q.push_back('{16'hCA60, 16'hC460, 16'hCC48});
    for (int i = 0; i < 14; i++) issue(dir_a[i], dir_b[i], dir_r[i]);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(1) == 1) rb[14:10] = ra[14:10] ^ 5'($urandom_range(3));
      issue(ra, rb, ref_add(ra, rb));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    @(negedge clk);
    Asem = 16'h3C00;
    Bsem = 16'h3C00;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Rsem !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset: got %h expected 0000", Rsem);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Rsem !== 16'h0000) begin
      failures++;
      $display("FAIL reset_midstream: got %h expected 0000", Rsem);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
